// File: rtl/alu_result_tx.sv
// Serializes one ALU result + zero flag as an 8N1 byte packet.
// Define ALU_RESULT_TX_CHECKSUM_EN to append an XOR checksum byte.
module alu_result_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        res_valid,
  output logic        res_ready,
  input  logic [15:0] res_data,
  input  logic        res_zero,
  output logic        tx,
  output logic        busy
);

`ifdef ALU_RESULT_TX_CHECKSUM_EN
  localparam int NBYTES = 4;
`else
  localparam int NBYTES = 3;
`endif
  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    byte_q, byte_d;
  logic [15:0]   data_q, data_d;
  logic          zero_q, zero_d;
  logic          tx_q, tx_d;

  logic [7:0] status;
  logic [7:0] cur_byte;
  logic       bit_end;
  logic       last_byte;
  logic       stop_end;

  assign status = 8'hA0 | {7'b0, zero_q};

  always_comb begin
    case (byte_q)
      2'd0: cur_byte = status;
      2'd1: cur_byte = data_q[15:8];
      2'd2: cur_byte = data_q[7:0];
`ifdef ALU_RESULT_TX_CHECKSUM_EN
      2'd3: cur_byte = status ^ data_q[15:8] ^ data_q[7:0];
`endif
      default: cur_byte = status;
    endcase
  end

  assign bit_end   = cnt_q == CW'(CLKS_PER_BIT - 1);
  assign last_byte = byte_q == 2'(NBYTES - 1);
  // tx lags the state by one cycle, so the final stop period in the
  // state machine is one cycle short; tx still holds it a full bit.
  assign stop_end  = last_byte ? (cnt_q == CW'(CLKS_PER_BIT - 2))
                               : bit_end;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    byte_d  = byte_q;
    data_d  = data_q;
    zero_d  = zero_q;
    tx_d    = 1'b1;
    unique case (state_q)
      IDLE: begin
        cnt_d  = '0;
        bit_d  = '0;
        byte_d = '0;
        if (res_valid) begin
          state_d = START;
          data_d  = res_data;
          zero_d  = res_zero;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (bit_end) begin
          cnt_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        tx_d = cur_byte[bit_q];
        if (bit_end) begin
          cnt_d = '0;
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (stop_end) begin
          cnt_d = '0;
          if (last_byte) begin
            state_d = IDLE;
            byte_d  = '0;
          end else begin
            state_d = START;
            byte_d  = byte_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      data_q  <= '0;
      zero_q  <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      data_q  <= data_d;
      zero_q  <= zero_d;
      tx_q    <= tx_d;
    end
  end

  assign res_ready = state_q == IDLE;
  assign busy      = ~res_ready;
  assign tx        = tx_q;

endmodule
